// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store engine over a single-port word RAM, sub-word stores done as read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_in,
    input  logic [31:0]       ram_out
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t st, nx;
    logic wr, uns, err, req_err;
    logic [1:0] sz;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata, old, sh, ld_data, rep, merged;
    logic [3:0] be;
    assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (!reset) begin
            st <= IDLE;
            wr <= 1'b0;
            sz <= 2'b00;
            uns <= 1'b0;
            err <= 1'b0;
            addr <= '0;
            wdata <= '0;
            old <= '0;
        end else begin
            st <= nx;
            if (st == IDLE && req_valid) begin
                wr <= req_write;
                sz <= req_size;
                uns <= req_unsigned;
                err <= req_err;
                addr <= req_addr;
                wdata <= req_wdata;
            end
            if (st == READ) old <= ram_out;
        end
    end
    // only full-word stores skip the read; everything else valid reads first
    always_comb begin
        nx = IDLE;
        case (st)
            IDLE:  nx = !req_valid ? IDLE : req_err ? RESP :
                        (req_write && req_size == 2'b10) ? WRITE : READ;
            READ:  nx = wr ? WRITE : RESP;
            WRITE: nx = RESP;
            RESP:  nx = IDLE;
            default: nx = IDLE;
        endcase
    end
    // halfwords are 2-byte aligned, so one byte-granular shift serves both sub-word loads
    assign sh = old >> {addr[1:0], 3'b000};
    assign ld_data = sz == 2'b00 ? {{24{~uns & sh[7]}}, sh[7:0]} :
                     sz == 2'b01 ? {{16{~uns & sh[15]}}, sh[15:0]} : old;
    assign be  = sz == 2'b00 ? 4'b0001 << addr[1:0] : sz == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign rep = sz == 2'b00 ? {4{wdata[7:0]}} : sz == 2'b01 ? {2{wdata[15:0]}} : wdata;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i+:8] = be[i] ? rep[8*i+:8] : old[8*i+:8];
    end
    assign req_ready   = !reset || st == IDLE;
    assign resp_valid  = reset && st == RESP;
    assign resp_error  = resp_valid && err;
    assign resp_rdata  = (resp_valid && !err && !wr) ? ld_data : 32'h0;
    assign ram_we      = reset && st == WRITE;
    assign ram_address = (reset && (st == READ || st == WRITE)) ? {addr[ADDR_W-1:2], 2'b00} : '0;
    assign ram_in      = ram_we ? merged : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a behavioural word RAM.
module tb_load_store_unit;
    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, resp_valid, resp_error, ram_we;
    logic [31:0] resp_rdata, ram_in, ram_out;
    logic [15:0] ram_address;
    logic [31:0] mem [0:63];
    int cmp = 0, bad = 0, we_cnt = 0;
    logic [31:0] we_addr, we_data;

    load_store_unit #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .ram_we(ram_we),
        .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;
    assign ram_out = mem[ram_address[7:2]];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address[7:2]] <= ram_in;
            we_cnt = we_cnt + 1;
            we_addr = {16'h0, ram_address};
            we_data = ram_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issues one request and checks latency, result, error flag and number of RAM writes
    task automatic req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [15:0] a, input logic [31:0] wd, input int lat,
                       input logic [31:0] rd, input logic er, input int nwe);
        int cyc, we0;
        chk({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        we0 = we_cnt;
        step();
        req_valid = 1'b0; req_wdata = 32'h0;
        cyc = 1;
        chk({tag, ".addr"}, {16'h0, ram_address}, lat > 1 ? {16'h0, a[15:2], 2'b00} : 32'h0);
        while (!resp_valid && cyc < 8) begin
            step();
            cyc++;
        end
        chk({tag, ".lat"}, cyc, lat);
        chk({tag, ".rdata"}, resp_rdata, rd);
        chk({tag, ".err"}, {31'h0, resp_error}, {31'h0, er});
        chk({tag, ".we"}, we_cnt - we0, nwe);
        step();
        chk({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        int we0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h8899AABB;
        mem[1] = 32'h11223344;
        mem[3] = 32'h55667788;
        step();
        step();
        chk("rst.ready", {31'h0, req_ready}, 32'h1);
        chk("rst.valid", {31'h0, resp_valid}, 32'h0);
        chk("rst.err", {31'h0, resp_error}, 32'h0);
        chk("rst.rdata", resp_rdata, 32'h0);
        chk("rst.we", {31'h0, ram_we}, 32'h0);
        chk("rst.addr", {16'h0, ram_address}, 32'h0);
        chk("rst.in", ram_in, 32'h0);
        reset = 1'b1;
        step();
        req("lb2s", 1'b0, 2'b00, 1'b0, 16'h0002, 32'h0, 2, 32'hFFFFFF99, 1'b0, 0);
        req("lb1u", 1'b0, 2'b00, 1'b1, 16'h0001, 32'h0, 2, 32'h000000AA, 1'b0, 0);
        req("lh2u", 1'b0, 2'b01, 1'b1, 16'h0002, 32'h0, 2, 32'h00008899, 1'b0, 0);
        req("lh2s", 1'b0, 2'b01, 1'b0, 16'h0002, 32'h0, 2, 32'hFFFF8899, 1'b0, 0);
        req("lw0", 1'b0, 2'b10, 1'b1, 16'h0000, 32'h0, 2, 32'h8899AABB, 1'b0, 0);
        req("sb5", 1'b1, 2'b00, 1'b0, 16'h0005, 32'h000000AB, 3, 32'h0, 1'b0, 1);
        chk("sb5.in", we_data, 32'h1122AB44);
        chk("sb5.mem", mem[1], 32'h1122AB44);
        req("sh6", 1'b1, 2'b01, 1'b0, 16'h0006, 32'h1234CAFE, 3, 32'h0, 1'b0, 1);
        chk("sh6.mem", mem[1], 32'hCAFEAB44);
        req("sw8", 1'b1, 2'b10, 1'b0, 16'h0008, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        chk("sw8.waddr", we_addr, 32'h8);
        chk("sw8.in", we_data, 32'hDEADBEEF);
        req("lw8", 1'b0, 2'b10, 1'b1, 16'h0008, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);
        req("lh3", 1'b0, 2'b01, 1'b0, 16'h0003, 32'h0, 1, 32'h0, 1'b1, 0);
        req("sz11", 1'b1, 2'b11, 1'b0, 16'h0000, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0);
        req("sw2", 1'b1, 2'b10, 1'b0, 16'h0002, 32'h01020304, 1, 32'h0, 1'b1, 0);
        chk("err.mem", mem[0], 32'h8899AABB);
        // reset while the read half of a byte store is in flight
        we0 = we_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 16'h000D; req_wdata = 32'h000000EE;
        step();
        req_valid = 1'b0;
        chk("abort.read", {16'h0, ram_address}, 32'hC);
        reset = 1'b0;
        #1;
        chk("abort.addr0", {16'h0, ram_address}, 32'h0);
        step();
        reset = 1'b1;
        chk("abort.ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("abort.valid", {31'h0, resp_valid}, 32'h0);
            chk("abort.we", {31'h0, ram_we}, 32'h0);
            step();
        end
        chk("abort.wecnt", we_cnt - we0, 0);
        chk("abort.mem", mem[3], 32'h55667788);
        req("post", 1'b0, 2'b00, 1'b0, 16'h000D, 32'h0, 2, 32'h00000077, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
